// File: rtl/asap7_dff_pkg.sv
// Shared definitions for the asap7_dff_pipe register slice.
// Contents: the occupancy-width helper, the default reset fill bit and the
// per-stage control bundle that the top passes into each stage.
package asap7_dff_pkg;

    // Bit replicated across WIDTH to form the default stage reset value.
    localparam logic RST_FILL_DEFAULT = 1'b0;

    // Per-stage control: the source valid bit and the load enable.
    // The load enable is the ready-chain term for that stage.
    typedef struct packed {
        logic valid;
        logic load;
    } stage_ctrl_t;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/asap7_dff_stage.sv
// One elastic pipeline stage: a WIDTH-bit data flop plus its valid flop.
// When load is high, the stage takes the source valid bit. It captures the
// source data only if that valid bit is set, so a loaded bubble keeps the old
// data. Flush clears the valid bit and leaves the data unchanged.
// INV_D stores the complement of the source data. This models a QN-output
// cell at the entry stage.
module asap7_dff_stage
    import asap7_dff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_FILL_DEFAULT}},
    parameter bit               INV_D   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  stage_ctrl_t      ctrl_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_pol_s;

    // Apply the storage polarity to the incoming word.
    always_comb begin
        data_pol_s = data_i;
        if (INV_D) begin
            data_pol_s = ~data_i;
        end else begin
            data_pol_s = data_i;
        end
    end

    // Next-state logic. Flush wins, a load takes the source, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = data_q;
        end else if (ctrl_i.load) begin
            valid_d = ctrl_i.valid;
            if (ctrl_i.valid) begin
                data_d = data_pol_s;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage flops. Reset is asynchronous and loads the stored reset word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/asap7_dff_pipe.sv
// asap7_dff_pipe: parametrised behavioural DFF pipeline with a valid/ready
// elastic handshake. It replaces gate-level DFF cells in simulation.
// Stage 0 is the input stage and stage DEPTH-1 drives Q/OUT_VALID.
// Bubbles collapse, OUT_READY back-pressure stalls the pipe, and FLUSH clears
// every valid bit synchronously.
// Optional build macro ASAP7_DFF_PIPE_QN_EN: stages hold the complement of the
// accepted word (DFFHQN polarity). Q then shows ~D, and reset shows ~RST_VAL.
module asap7_dff_pipe
    import asap7_dff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_FILL_DEFAULT}}
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         D,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         Q,
    output logic [occ_w(DEPTH)-1:0]  OCC
);

    localparam int OCC_W = occ_w(DEPTH);

`ifdef ASAP7_DFF_PIPE_QN_EN
    localparam bit QN_EN = 1'b1;
`else
    localparam bit QN_EN = 1'b0;
`endif

    // The complement is taken once, at entry. Later stages copy the stored
    // word as it is, so every stage resets to the same stored polarity.
    localparam logic [WIDTH-1:0] STORE_RST = QN_EN ? ~RST_VAL : RST_VAL;

    logic [DEPTH:0]     rdy_s;
    logic               chain_s;
    logic [DEPTH-1:0]   v_s;
    logic [DEPTH-1:0]   src_valid_s;
    logic [WIDTH-1:0]   src_data_s   [DEPTH];
    logic [WIDTH-1:0]   stage_data_s [DEPTH];
    logic               in_xfer_s;
    logic               out_xfer_s;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;

    // Ready chain, walked from the output end. A stage can load if it is
    // empty or if everything downstream of it can move.
    always_comb begin
        rdy_s        = {(DEPTH + 1){1'b0}};
        rdy_s[DEPTH] = OUT_READY;
        chain_s      = OUT_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain_s  = ~v_s[i] | chain_s;
            rdy_s[i] = chain_s;
        end
    end

    // Stage array. Stage 0 takes its source from the input port, and each
    // later stage takes its source from the stage before it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        stage_ctrl_t ctrl_s;

        if (g == 0) begin : g_src_in
            assign src_valid_s[g] = IN_VALID;
            assign src_data_s[g]  = D;
        end else begin : g_src_prev
            assign src_valid_s[g] = v_s[g-1];
            assign src_data_s[g]  = stage_data_s[g-1];
        end

        assign ctrl_s.valid = src_valid_s[g];
        assign ctrl_s.load  = rdy_s[g];

        asap7_dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (STORE_RST),
            .INV_D   ((g == 0) ? QN_EN : 1'b0)
        ) u_stage (
            .clk     (CLK),
            .rst_n   (RESETN),
            .flush_i (FLUSH),
            .ctrl_i  (ctrl_s),
            .data_i  (src_data_s[g]),
            .valid_o (v_s[g]),
            .data_o  (stage_data_s[g])
        );
    end

    // Flush masks both handshake sides, so no transfer can happen in a
    // flush cycle.
    assign IN_READY  = rdy_s[0] & ~FLUSH;
    assign OUT_VALID = v_s[DEPTH-1] & ~FLUSH;
    assign Q         = stage_data_s[DEPTH-1];

    assign in_xfer_s  = IN_VALID & IN_READY;
    assign out_xfer_s = OUT_VALID & OUT_READY;

    // Occupancy next state. The ready chain keeps it within 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (FLUSH) begin
            occ_d = {OCC_W{1'b0}};
        end else if (in_xfer_s && !out_xfer_s) begin
            occ_d = occ_q + OCC_W'(1'b1);
        end else if (!in_xfer_s && out_xfer_s) begin
            occ_d = occ_q - OCC_W'(1'b1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;

endmodule
